// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_SHL  = 2'd2,
    OP_SHR  = 2'd3
  } usr_op_e;

  localparam int unsigned FILL_ZERO   = 0;
  localparam int unsigned FILL_ROTATE = 1;

endpackage : usr_pkg

// File: rtl/usr_op_decode.sv
// Priority decode of the control inputs into a single operation code.
module usr_op_decode
  import usr_pkg::*;
(
  input  logic    enable_i,
  input  logic    parallel_load_i,
  input  logic    shift_left_i,
  input  logic    shift_right_i,
  output usr_op_e op_c_o
);

  // Load beats shift-left beats shift-right; disabled means hold.
  always_comb begin
    op_c_o = OP_HOLD;
    if (enable_i) begin
      if (parallel_load_i) begin
        op_c_o = OP_LOAD;
      end else if (shift_left_i) begin
        op_c_o = OP_SHL;
      end else if (shift_right_i) begin
        op_c_o = OP_SHR;
      end
    end
  end

endmodule : usr_op_decode

// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, logical/rotating shift left or right, hold.
// Output is taken straight from the state register.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     FILL_MODE   = FILL_ZERO,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic             parallel_load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out
);

  usr_op_e          op_c;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             fill_l_c;
  logic             fill_r_c;

  usr_op_decode u_op_decode (
    .enable_i        (enable),
    .parallel_load_i (parallel_load),
    .shift_left_i    (shift_left),
    .shift_right_i   (shift_right),
    .op_c_o          (op_c)
  );

  // Vacated bit is either zero or the bit leaving the opposite end.
  assign fill_l_c = (FILL_MODE == FILL_ROTATE) ? data_q[WIDTH-1] : 1'b0;
  assign fill_r_c = (FILL_MODE == FILL_ROTATE) ? data_q[0]       : 1'b0;

  always_comb begin
    data_d = data_q;
    unique case (op_c)
      OP_LOAD: data_d = data_in;
      OP_SHL:  data_d = {data_q[WIDTH-2:0], fill_l_c};
      OP_SHR:  data_d = {fill_r_c, data_q[WIDTH-1:1]};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: one zero-fill and one rotating instance.
module tb_universal_shift_register;

  logic       clk;
  logic       reset;
  logic       shift_left;
  logic       shift_right;
  logic       parallel_load;
  logic [7:0] data_in;
  logic       enable;
  logic [7:0] dout_z;
  logic [7:0] dout_r;

  int unsigned n_cmp;
  int unsigned n_err;

  universal_shift_register #(.WIDTH(8), .FILL_MODE(0), .RESET_VALUE(8'h00)) dut_zero (
    .clk           (clk),
    .reset         (reset),
    .shift_left    (shift_left),
    .shift_right   (shift_right),
    .parallel_load (parallel_load),
    .data_in       (data_in),
    .enable        (enable),
    .data_out      (dout_z)
  );

  universal_shift_register #(.WIDTH(8), .FILL_MODE(1), .RESET_VALUE(8'h00)) dut_rot (
    .clk           (clk),
    .reset         (reset),
    .shift_left    (shift_left),
    .shift_right   (shift_right),
    .parallel_load (parallel_load),
    .data_in       (data_in),
    .enable        (enable),
    .data_out      (dout_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic en, input logic ld, input logic sl, input logic sr,
                         input logic [7:0] din);
    enable        = en;
    parallel_load = ld;
    shift_left    = sl;
    shift_right   = sr;
    data_in       = din;
  endtask

  logic [7:0] shl_z [5] = '{8'b01010100, 8'b10101000, 8'b01010000, 8'b10100000, 8'b01000000};
  logic [7:0] shl_r [5] = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
  logic [7:0] shr_z [8] = '{8'b01010101, 8'b00101010, 8'b00010101, 8'b00001010,
                            8'b00000101, 8'b00000010, 8'b00000001, 8'b00000000};

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    check_eq("reset_init_z", dout_z, 8'h00);
    check_eq("reset_init_r", dout_r, 8'h00);
    step();
    reset = 1'b1;

    // Load A5, then assert reset mid-cycle
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    step();
    check_eq("load_a5", dout_z, 8'hA5);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_reset_z", dout_z, 8'h00);
    check_eq("async_reset_r", dout_r, 8'h00);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    step();
    check_eq("reset_held", dout_z, 8'h00);
    reset = 1'b1;

    // Load gated by enable
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 8'b10101010);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("load_gated", dout_z, 8'h00);
    end
    enable = 1'b1;
    step();
    check_eq("load_en_z", dout_z, 8'b10101010);
    check_eq("load_en_r", dout_r, 8'b10101010);
    step();
    check_eq("load_repeat", dout_z, 8'b10101010);

    // Shift left five times; data_in changed but must be ignored
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("shl_z", dout_z, shl_z[i]);
      check_eq("shl_r", dout_r, shl_r[i]);
    end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("shl_hold_z", dout_z, 8'b01000000);
      check_eq("shl_hold_r", dout_r, 8'h55);
    end

    // Shift right until empty
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'b10101010);
    step();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("shr_z", dout_z, shr_z[i]);
      check_eq("shr_r", dout_r, (i % 2 == 0) ? 8'h55 : 8'hAA);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("shr_empty", dout_z, 8'h00);
    end

    // Priority
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
    step();
    check_eq("prio_load_z", dout_z, 8'h3C);
    check_eq("prio_load_r", dout_r, 8'h3C);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    step();
    check_eq("prio_shl_z", dout_z, 8'h78);
    check_eq("prio_shl_r", dout_r, 8'h78);

    // Rotate vs zero fill from 8'b10000001
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'b10000001);
    step();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check_eq("rot_shr1_r", dout_r, 8'b11000000);
    check_eq("rot_shr1_z", dout_z, 8'b01000000);

    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'b10000001);
    step();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check_eq("rot_shl1_r", dout_r, 8'b00000011);
    check_eq("rot_shl1_z", dout_z, 8'b00000010);

    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'b10000001);
    step();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step();
    check_eq("rot_shr8_r", dout_r, 8'b10000001);
    check_eq("rot_shr8_z", dout_z, 8'h00);

    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 8'b10000001);
    step();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step();
    check_eq("rot_shl8_r", dout_r, 8'b10000001);
    check_eq("rot_shl8_z", dout_z, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_universal_shift_register

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- 8-bit (parameterisable) universal shift register: parallel load, logical shift left, logical shift right, or hold.
- All operations are gated by a common enable.
- General-purpose datapath primitive for serialisers, scalers and test-pattern generators; single clock domain, registered output.

Parameters:
- WIDTH, 8, register width in bits (minimum 2)
- FILL_MODE, 0, vacated-bit source on shifts: 0 = shift in zero, 1 = rotate (bit shifted out re-enters at the opposite end)
- RESET_VALUE, 0 (WIDTH bits), value loaded into the register on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- shift_left  input  1  request shift toward MSB
- shift_right  input  1  request shift toward LSB
- parallel_load  input  1  request load of data_in
- data_in  input  WIDTH  parallel load data
- enable  input  1  global operation enable; when 0 the register holds
- data_out  output  WIDTH  current register contents (direct register output, no combinational path from inputs)

Behaviour:
- Reset:
  - reset = 0 immediately forces the register, and therefore data_out, to RESET_VALUE, independent of clk.
  - The register stays at RESET_VALUE while reset is 0.
  - Deassertion is synchronised by the clock edge; the first operation takes effect at the first rising edge with reset = 1.
- Reset mid-operation: the register clears asynchronously; no pending operation survives.
- Each rising clk edge with reset = 1 and enable = 1 applies exactly one operation, in this priority:
  1. parallel_load = 1: reg <= data_in
  2. else shift_left = 1: reg <= {reg[WIDTH-2:0], fill_l}; fill_l = 0 if FILL_MODE = 0, reg[WIDTH-1] if FILL_MODE = 1
  3. else shift_right = 1: reg <= {fill_r, reg[WIDTH-1:1]}; fill_r = 0 if FILL_MODE = 0, reg[0] if FILL_MODE = 1
  4. else: hold
- enable = 0: hold, regardless of the other controls.
- Simultaneous shift_left and shift_right (no load): shift left wins.
- Latency: one cycle. data_out reflects the operation after the same rising edge that sampled the controls.
- Continuous shifting: one bit position per enabled cycle. With FILL_MODE = 0, WIDTH consecutive shifts empty the register to all zeros. With FILL_MODE = 1, WIDTH consecutive shifts return the original value.
- data_in is ignored unless a load is applied.
- No handshake and no status outputs.

Decomposition:
- Shared package usr_pkg:
  - op encoding typedef: OP_HOLD, OP_LOAD, OP_SHL, OP_SHR
  - FILL_ZERO / FILL_ROTATE constants
- One natural sub-module, usr_op_decode: combinational priority decode of enable/parallel_load/shift_left/shift_right into the op code.
- Top level: datapath mux plus register.

Test Plan:
- Reset: drive reset = 0 mid-cycle while the register holds 8'hA5 -> data_out = 8'h00 immediately, before the next clk edge; stays 0 until reset = 1.
- Load gating: parallel_load = 1, data_in = 8'b10101010, enable = 0 for 3 cycles -> data_out stays 8'h00; raise enable -> data_out = 8'b10101010 after one edge; repeated loads keep that value.
- Shift left, FILL_MODE = 0: from 8'b10101010, enable = 1, shift_left = 1 for 5 cycles -> 01010100, 10101000, 01010000, 10100000, 01000000; deassert enable -> holds 01000000.
- Shift right, FILL_MODE = 0: from 8'b10101010, shift_right = 1 for 8 cycles -> 01010101, 00101010, ... , 00000000; further shifts stay 0.
- Priority: all of parallel_load, shift_left, shift_right = 1 with data_in = 8'h3C -> 8'h3C. Then shift_left = shift_right = 1 (no load) -> 8'h78.
- Rotate, FILL_MODE = 1: load 8'b10000001; one shift right -> 11000000; one shift left from 8'b10000001 -> 00000011; 8 shifts either direction return 8'b10000001.
